read_port_responder: RTL and testbench
======================================

READ_PORT_RESPONDER -- requirements
Module: read_port_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25, meaning the width of the byte address on both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width of a data word.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for readdatavalid before aborting the read.
REQ-004 SHALL have port `clock`, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port `read_n`, input, 1 bit: requester read request, active low, level-held.
REQ-007 SHALL have port `read_address`, input, ADDR_WIDTH bits: requester word address; bits [1:0] are ignored.
REQ-008 SHALL have port `read_data`, output, DATA_WIDTH bits: returned word.
REQ-009 SHALL have port `data_ready_n`, output, 1 bit: read_data is valid, active low.
REQ-010 SHALL have port `timeout_error`, output, 1 bit: sticky flag for an aborted read.
REQ-011 SHALL have port `avm_address`, output, ADDR_WIDTH bits: Avalon-MM master address.
REQ-012 SHALL have port `avm_read`, output, 1 bit: Avalon-MM read strobe.
REQ-013 SHALL have port `avm_byteenable`, output, 4 bits: Avalon-MM byte enables, constant 4'hF.
REQ-014 SHALL have port `avm_waitrequest`, input, 1 bit: slave stall.
REQ-015 SHALL have port `avm_readdata`, input, DATA_WIDTH bits: slave data.
REQ-016 SHALL have port `avm_readdatavalid`, input, 1 bit: slave data valid.

Function
REQ-017 SHALL implement four states: IDLE, ISSUE, WAIT, HOLD.
REQ-018 IDLE: when read_n is 0, SHALL latch {read_address[ADDR_WIDTH-1:2], 2'b00} as req_addr and go to ISSUE on the next cycle.
REQ-019 ISSUE: SHALL drive avm_read=1 and avm_address=req_addr; when avm_waitrequest is 0 in a cycle, SHALL go to WAIT and clear the timeout counter.
REQ-020 SHALL drive avm_read=0 in every state except ISSUE.
REQ-021 WAIT: when avm_readdatavalid is 1, SHALL capture avm_readdata into read_data and go to HOLD.
REQ-022 HOLD: SHALL drive data_ready_n=0 while read_n=0 and the masked read_address equals req_addr.
REQ-023 HOLD: when read_n=1, SHALL drive data_ready_n=1 in the same cycle (combinational) and go to IDLE.
REQ-024 HOLD: when read_n=0 and the address differs, SHALL drive data_ready_n=1 combinationally, latch the new address and go to ISSUE.
REQ-025 Minimum latency, with zero waitrequest and readdatavalid one cycle after acceptance: read_n falls in cycle 0, avm_read in cycle 1, data_ready_n=0 in cycle 3.
REQ-026 Address change during ISSUE (read not yet accepted): SHALL replace req_addr and re-present the new address with no Avalon transaction lost.
REQ-027 Address change or read_n=1 during WAIT: SHALL still absorb the outstanding readdatavalid (discarded), then go to ISSUE with the new address or to IDLE.
REQ-028 Timeout counter: SHALL be ceil(log2(TIMEOUT+1)) bits and increment each cycle in WAIT.
REQ-029 When the counter reaches TIMEOUT in WAIT, SHALL load read_data=32'hDEADBEEF, set timeout_error=1 and go to HOLD.
REQ-030 After a timeout, a late avm_readdatavalid SHALL be ignored and have no effect.
REQ-031 A readdatavalid in IDLE, ISSUE or HOLD SHALL be ignored.
REQ-032 timeout_error SHALL clear only on reset.

Reset
REQ-033 While reset=1 at a clock edge: state=IDLE, avm_read=0, avm_address=0, read_data=0, timeout_error=0, counter=0.
REQ-034 While reset=1, data_ready_n SHALL be 1.
REQ-035 Reset mid-transaction SHALL abandon the outstanding read; the next readdatavalid after reset SHALL be ignored (arrives in IDLE).

Verification
REQ-036 Scenario: read_n=0, read_address=25'h000_1237, waitrequest=0, readdatavalid with 32'h1234_5678 one cycle after acceptance -> avm_address=25'h000_1234, data_ready_n=0 in cycle 3, read_data=32'h1234_5678 held until read_n=1.
REQ-037 Scenario: waitrequest=1 for 5 cycles -> avm_read and avm_address stay stable all 5 cycles; exactly one accepted read.
REQ-038 Scenario: address changes 0x100 -> 0x200 while in WAIT -> first readdata discarded, second read issued at 0x200, data_ready_n=0 only with the 0x200 data.
REQ-039 Scenario: HOLD at 0x100, address switches to 0x104 with read_n=0 -> data_ready_n=1 that same cycle, new read issued at 0x104 next cycle.
REQ-040 Scenario: no readdatavalid for TIMEOUT=4 cycles -> read_data=32'hDEADBEEF, data_ready_n=0, timeout_error=1; a later readdatavalid has no effect.
REQ-041 Scenario: reset asserted in WAIT -> next cycle outputs at reset values; subsequent readdatavalid ignored; a new request completes normally.

Source files
------------

// File: rtl/read_port_responder.sv
// Read-port responder: turns a level-held, active-low read request into one
// Avalon-MM read, then holds the returned word until the requester lets go.
module read_port_responder #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_n,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  data_ready_n,
  output logic                  timeout_error,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic [3:0]            avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_WIDTH-1:0] avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  timeout_error_q, timeout_error_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  avm_read_q, avm_read_d;
  logic [ADDR_WIDTH-1:0] avm_address_q, avm_address_d;

  logic [ADDR_WIDTH-1:0] masked_addr;
  logic                  addr_match;

  assign masked_addr = {read_address[ADDR_WIDTH-1:2], 2'b00};
  assign addr_match  = (masked_addr == req_addr_q);

  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    read_data_d     = read_data_q;
    timeout_error_d = timeout_error_q;
    cnt_d           = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!read_n) begin
          req_addr_d = masked_addr;
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      // Once accepted, the read is in flight; a later address change is
      // resolved when its data comes back.
      S_ISSUE: begin
        if (!avm_waitrequest) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (!read_n && !addr_match) begin
          req_addr_d = masked_addr;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (avm_readdatavalid) begin
          if (read_n) begin
            state_d = S_IDLE;
          end else if (addr_match) begin
            read_data_d = avm_readdata;
            state_d     = S_HOLD;
          end else begin
            req_addr_d = masked_addr;
            state_d    = S_ISSUE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          read_data_d     = DATA_WIDTH'(32'hDEADBEEF);
          timeout_error_d = 1'b1;
          state_d         = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (read_n) begin
          state_d = S_IDLE;
        end else if (!addr_match) begin
          req_addr_d = masked_addr;
          state_d    = S_ISSUE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Avalon outputs are registered from the next state so they are glitch-free.
  always_comb begin
    avm_read_d    = (state_d == S_ISSUE);
    avm_address_d = req_addr_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      req_addr_q      <= '0;
      read_data_q     <= '0;
      timeout_error_q <= 1'b0;
      cnt_q           <= '0;
      avm_read_q      <= 1'b0;
      avm_address_q   <= '0;
    end else begin
      state_q         <= state_d;
      req_addr_q      <= req_addr_d;
      read_data_q     <= read_data_d;
      timeout_error_q <= timeout_error_d;
      cnt_q           <= cnt_d;
      avm_read_q      <= avm_read_d;
      avm_address_q   <= avm_address_d;
    end
  end

  // Ready must drop in the same cycle the requester releases or moves away.
  assign data_ready_n   = ~(~reset & (state_q == S_HOLD) & ~read_n & addr_match);
  assign read_data      = read_data_q;
  assign timeout_error  = timeout_error_q;
  assign avm_read       = avm_read_q;
  assign avm_address    = avm_address_q;
  assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_read_port_responder.sv
// Bench for read_port_responder: a latency-programmable Avalon slave with a
// known memory image, directed scenarios and a randomized request stream.
module tb_read_port_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_n;
  logic [24:0] read_address;
  logic [31:0] read_data;
  logic        data_ready_n;
  logic        timeout_error;
  logic [24:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int checks = 0;
  int errs   = 0;

  // slave / monitor state
  bit          slave_pend = 1'b0;
  int          slave_cnt  = 0;
  int          slave_lat  = 1;
  logic [24:0] slave_addr = '0;
  int          accept_cnt = 0;
  logic [24:0] last_acc   = '0;
  bit          wr_random  = 1'b0;
  bit          expect_dead = 1'b0;

  read_port_responder #(.ADDR_WIDTH(25), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .read_n(read_n), .read_address(read_address),
    .read_data(read_data), .data_ready_n(data_ready_n), .timeout_error(timeout_error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [24:0] a);
    if (a == 25'h000_1234) return 32'h1234_5678;
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [24:0] mask_addr(input logic [24:0] a);
    return {a[24:2], 2'b00};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  // From the start of a cycle, advance until data_ready_n is low; stops at that negedge.
  task automatic wait_ready(input string tag, input int bound, output int n);
    n = 0;
    mid();
    while (data_ready_n && n < bound) begin
      step();
      mid();
      n++;
    end
    if (n >= bound) check_val({tag, "_timeout"}, 64'(data_ready_n), 64'd0);
  endtask

  // Slave: answers an accepted read slave_lat cycles later; randomizes waitrequest on demand.
  initial begin
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      avm_readdatavalid = 1'b0;
      if (slave_pend) begin
        if (slave_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = mem_word(slave_addr);
          slave_pend        = 1'b0;
        end else begin
          slave_cnt--;
        end
      end
      if (wr_random) avm_waitrequest = ($urandom_range(2) == 0);
    end
  end

  // Monitor: any presented word must belong to the address currently requested.
  initial begin
    forever begin
      @(negedge clock);
      if (!data_ready_n) begin
        check_val("rdy_read_n", 64'(read_n), 64'd0);
        check_val("rdy_data", 64'(read_data),
                  expect_dead ? 64'h0000_0000_DEAD_BEEF : 64'(mem_word(mask_addr(read_address))));
      end
      if (avm_read) check_val("byteenable", 64'(avm_byteenable), 64'hF);
      if (avm_read && !avm_waitrequest) begin
        accept_cnt++;
        last_acc   = avm_address;
        slave_pend = 1'b1;
        slave_cnt  = slave_lat - 1;
        slave_addr = avm_address;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int a0;
    logic [24:0] ra;

    reset = 1'b1; read_n = 1'b1; read_address = 25'h0; avm_waitrequest = 1'b0;
    repeat (3) step();
    read_n = 1'b0;
    mid();
    check_val("rst_avm_read", 64'(avm_read), 64'd0);
    check_val("rst_avm_addr", 64'(avm_address), 64'd0);
    check_val("rst_read_data", 64'(read_data), 64'd0);
    check_val("rst_timeout", 64'(timeout_error), 64'd0);
    check_val("rst_ready_n", 64'(data_ready_n), 64'd1);
    step();
    read_n = 1'b1; reset = 1'b0;
    step();

    // minimum latency read
    read_n = 1'b0; read_address = 25'h000_1237; slave_lat = 1;
    mid(); check_val("s1_c0_read", 64'(avm_read), 64'd0);
    step(); mid();
    check_val("s1_c1_read", 64'(avm_read), 64'd1);
    check_val("s1_c1_addr", 64'(avm_address), 64'h1234);
    step(); mid();
    check_val("s1_c2_ready", 64'(data_ready_n), 64'd1);
    step(); mid();
    check_val("s1_c3_ready", 64'(data_ready_n), 64'd0);
    check_val("s1_c3_data", 64'(read_data), 64'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step(); mid();
      check_val("s1_hold_ready", 64'(data_ready_n), 64'd0);
      check_val("s1_hold_data", 64'(read_data), 64'h1234_5678);
    end
    step();
    read_n = 1'b1;
    mid(); check_val("s1_release", 64'(data_ready_n), 64'd1);
    step(); mid(); check_val("s1_idle_read", 64'(avm_read), 64'd0);
    step();

    // stalled acceptance
    a0 = accept_cnt;
    read_n = 1'b0; read_address = 25'h000_2000; avm_waitrequest = 1'b1; slave_lat = 2;
    step();
    for (int i = 0; i < 5; i++) begin
      mid();
      check_val("s2_stall_read", 64'(avm_read), 64'd1);
      check_val("s2_stall_addr", 64'(avm_address), 64'h2000);
      step();
    end
    avm_waitrequest = 1'b0;
    wait_ready("s2_ready", 20, n);
    check_val("s2_data", 64'(read_data), 64'(mem_word(25'h2000)));
    check_val("s2_accepts", 64'(accept_cnt - a0), 64'd1);
    step(); read_n = 1'b1; step(); step();

    // address change during WAIT
    a0 = accept_cnt;
    read_n = 1'b0; read_address = 25'h100; slave_lat = 3;
    step(); step();
    read_address = 25'h200;
    wait_ready("s3_ready", 20, n);
    check_val("s3_latency", 64'(n), 64'd7);
    check_val("s3_data", 64'(read_data), 64'(mem_word(25'h200)));
    check_val("s3_accepts", 64'(accept_cnt - a0), 64'd2);
    check_val("s3_last_addr", 64'(last_acc), 64'h200);
    step(); read_n = 1'b1; step(); step();

    // address change during HOLD
    read_n = 1'b0; read_address = 25'h100; slave_lat = 1;
    wait_ready("s4_ready0", 20, n);
    check_val("s4_data0", 64'(read_data), 64'(mem_word(25'h100)));
    step();
    read_address = 25'h104;
    mid(); check_val("s4_drop", 64'(data_ready_n), 64'd1);
    step(); mid();
    check_val("s4_reissue", 64'(avm_read), 64'd1);
    check_val("s4_reissue_addr", 64'(avm_address), 64'h104);
    step();
    wait_ready("s4_ready1", 20, n);
    check_val("s4_data1", 64'(read_data), 64'(mem_word(25'h104)));
    step(); read_n = 1'b1; step(); step();

    // timeout with a late response
    expect_dead = 1'b1;
    read_n = 1'b0; read_address = 25'h300; slave_lat = 8;
    wait_ready("s5_ready", 20, n);
    check_val("s5_latency", 64'(n), 64'd7);
    check_val("s5_data", 64'(read_data), 64'hDEAD_BEEF);
    check_val("s5_error", 64'(timeout_error), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(); mid();
      check_val("s5_late_ready", 64'(data_ready_n), 64'd0);
      check_val("s5_late_data", 64'(read_data), 64'hDEAD_BEEF);
    end
    step();
    read_n = 1'b1; expect_dead = 1'b0;
    step(); step();
    read_n = 1'b0; read_address = 25'h500; slave_lat = 2;
    wait_ready("s5_next", 20, n);
    check_val("s5_next_data", 64'(read_data), 64'(mem_word(25'h500)));
    check_val("s5_sticky", 64'(timeout_error), 64'd1);
    step(); read_n = 1'b1; step(); step();

    // reset during WAIT
    read_n = 1'b0; read_address = 25'h400; slave_lat = 3;
    step(); step();
    reset = 1'b1; read_n = 1'b1;
    mid(); check_val("s6_rst_ready", 64'(data_ready_n), 64'd1);
    step();
    reset = 1'b0;
    mid();
    check_val("s6_avm_read", 64'(avm_read), 64'd0);
    check_val("s6_avm_addr", 64'(avm_address), 64'd0);
    check_val("s6_read_data", 64'(read_data), 64'd0);
    check_val("s6_error", 64'(timeout_error), 64'd0);
    step(); step(); mid();
    check_val("s6_ignored_data", 64'(read_data), 64'd0);
    check_val("s6_ignored_read", 64'(avm_read), 64'd0);
    step();
    read_n = 1'b0; read_address = 25'h600; slave_lat = 1;
    wait_ready("s6_new", 20, n);
    check_val("s6_new_latency", 64'(n), 64'd3);
    check_val("s6_new_data", 64'(read_data), 64'(mem_word(25'h600)));
    step(); read_n = 1'b1; step(); step();

    // randomized request stream with random stalls and latencies
    wr_random = 1'b1;
    for (int t = 0; t < 40; t++) begin
      ra = 25'($urandom);
      slave_lat = $urandom_range(1, 4);
      read_n = 1'b0; read_address = ra;
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 3)) step();
        ra = 25'($urandom);
        read_address = ra;
      end
      wait_ready("rnd_ready", 60, n);
      check_val("rnd_data", 64'(read_data), 64'(mem_word(mask_addr(ra))));
      step();
      if ($urandom_range(1) == 0) begin
        read_n = 1'b1;
        repeat ($urandom_range(1, 2)) step();
      end
    end
    wr_random = 1'b0;
    read_n = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
